// File: rtl/minterm_equiv_if.sv
// Signal bundle between the truth-table sweeper and the two functions it
// exercises: start request, function outputs, stimulus and sweep results.
interface minterm_equiv_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            f_a;
  logic            f_b;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] first_fail_m;
  logic            first_fail_vld;

  modport master (
    input  start, f_a, f_b,
    output stim, busy, done, pass, mismatch_cnt, first_fail_m, first_fail_vld
  );

  modport slave (
    output start, f_a, f_b,
    input  stim, busy, done, pass, mismatch_cnt, first_fail_m, first_fail_vld
  );
endinterface

// File: rtl/minterm_equiv_checker.sv
// Sweeps every minterm onto stim, lets the two functions settle, compares
// their outputs and records the mismatch count and lowest failing minterm.
module minterm_equiv_checker #(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  minterm_equiv_if.master bus
);

  localparam int                CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N_IN-1:0]   LAST_M      = '1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [N_IN-1:0]   STIM_ONE    = N_IN'(1);
  localparam logic [N_IN:0]     MIS_ONE     = (N_IN + 1)'(1);

  typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             sweep_go;
  logic             settle_end;
  logic             mismatch;
  logic             last_m;

  assign settle_end = (settle_cnt == SETTLE_LAST);
  // Case inequality so an undriven or unknown function output is a failure.
  assign mismatch   = (bus.f_a !== bus.f_b);
  assign last_m     = (bus.stim == LAST_M);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sweep_go  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          sweep_go  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE:  if (settle_end) state_nxt = COMPARE;
      COMPARE: state_nxt = last_m ? DONE : SETTLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stim           <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.mismatch_cnt   <= '0;
      bus.first_fail_m   <= '0;
      bus.first_fail_vld <= 1'b0;
      settle_cnt         <= '0;
    end else begin
      // done is the registered image of the DONE state: a single-cycle pulse.
      bus.done <= (state == DONE);
      case (state)
        IDLE: begin
          if (sweep_go) begin
            bus.stim           <= '0;
            bus.mismatch_cnt   <= '0;
            bus.first_fail_vld <= 1'b0;
            bus.first_fail_m   <= '0;
            bus.pass           <= 1'b0;
            bus.busy           <= 1'b1;
            settle_cnt         <= '0;
          end
        end
        SETTLE: settle_cnt <= settle_end ? '0 : settle_cnt + CNT_ONE;
        COMPARE: begin
          if (mismatch) begin
            bus.mismatch_cnt <= bus.mismatch_cnt + MIS_ONE;
            if (!bus.first_fail_vld) begin
              bus.first_fail_m   <= bus.stim;
              bus.first_fail_vld <= 1'b1;
            end
          end
          if (!last_m) bus.stim <= bus.stim + STIM_ONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          bus.pass <= (bus.mismatch_cnt == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
